// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage instructions, branch and data
// memory handshake toward the controller; stage enables/clears, state and
// performance counters back to the pipeline.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      id_inst;
  logic [31:0]      ex_inst;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_clr;
  logic             idex_en;
  logic             idex_clr;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_inst, ex_inst, ex_br_taken, mem_req, mem_ack,
    input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
    input  state, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_inst, ex_inst, ex_br_taken, mem_req, mem_ack,
    output pc_en, ifid_en, ifid_clr, idex_en, idex_clr,
    output state, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, two-cycle
// branch flush (synchronous IMEM), data-memory wait with timeout to ERR,
// and saturating stall/flush performance counters.
//
// state    | meaning
// RUN      | normal flow; detect memstall, taken branch, load-use
// FLUSH    | second wrong-path fetch being discarded from IF/ID
// MEM_WAIT | data memory access outstanding, pipeline frozen
// ERR      | memory timed out; frozen until reset
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_q, state_nx;
  logic [7:0]       wait_q, wait_nx;
  logic             pend_q, pend_nx;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             flush_inc;

  logic             pc_en, ifid_en, ifid_clr, idex_en, idex_clr;
  logic             id_rs1, id_rs2, lu, memstall;
  logic [6:0]       id_op, ex_op;
  logic [4:0]       ex_rd;
  logic             unused_bits;

  assign id_op    = bus.id_inst[6:0];
  assign ex_op    = bus.ex_inst[6:0];
  assign ex_rd    = bus.ex_inst[11:7];
  assign memstall = bus.mem_req & ~bus.mem_ack;

  assign unused_bits = ^{bus.id_inst[31:25], bus.id_inst[14:7], bus.ex_inst[31:12]};

  // Which source registers the instruction in ID actually reads.
  always_comb begin
    id_rs1 = 1'b0;
    id_rs2 = 1'b0;
    if (bus.id_inst != 32'd0) begin
      case (id_op)
        OP_IMM, OP_LOAD, OP_JALR: id_rs1 = 1'b1;
        OP_REG, OP_STORE, OP_BRANCH: begin
          id_rs1 = 1'b1;
          id_rs2 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign lu = (ex_op == OP_LOAD) && (ex_rd != 5'd0) &&
              ((id_rs1 && (bus.id_inst[19:15] == ex_rd)) ||
               (id_rs2 && (bus.id_inst[24:20] == ex_rd)));

  // Next state and stage control; reset forces the RUN defaults.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_en   = 1'b1;
    idex_clr  = 1'b0;
    state_nx  = state_q;
    wait_nx   = wait_q;
    pend_nx   = pend_q;
    flush_inc = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN, FLUSH: begin
          if (memstall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            wait_nx  = 8'd1;
            state_nx = MEM_WAIT;
            // A flush interrupted by the stall must still discard IF/ID later.
            if (state_q == FLUSH) pend_nx = 1'b1;
          end else if (state_q == FLUSH) begin
            ifid_clr = 1'b1;
            state_nx = RUN;
          end else if (bus.ex_br_taken) begin
            ifid_clr  = 1'b1;
            idex_clr  = 1'b1;
            flush_inc = 1'b1;
            state_nx  = FLUSH;
          end else if (lu) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.mem_ack) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            if (wait_q == TIMEOUT_LIM) state_nx = ERR;
            else wait_nx = wait_q + 8'd1;
          end else begin
            state_nx = RUN;
            pend_nx  = 1'b0;
            if (bus.ex_br_taken) begin
              ifid_clr  = 1'b1;
              idex_clr  = 1'b1;
              flush_inc = 1'b1;
              state_nx  = FLUSH;
            end else if (lu) begin
              pc_en    = 1'b0;
              ifid_en  = 1'b0;
              idex_clr = 1'b1;
            end
            if (pend_q) ifid_clr = 1'b1;
          end
        end
        default: begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_en = 1'b0;
        end
      endcase
    end
  end

  // State, wait timer and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      pend_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_nx;
      wait_q  <= wait_nx;
      pend_q  <= pend_nx;
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_clr    = ifid_clr;
  assign bus.idex_en     = idex_en;
  assign bus.idex_clr    = idex_clr;
  assign bus.state       = state_q;
  assign bus.mem_timeout = (state_q == ERR);
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, flush, memory wait/timeout,
// reset behaviour, plus a narrow-counter instance for saturation.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errs;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  b2 ();

  pipe_hazard_ctrl #(.TIMEOUT_CYC(255), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pipe_hazard_ctrl #(.TIMEOUT_CYC(255), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  assign b2.id_inst     = bus.id_inst;
  assign b2.ex_inst     = bus.ex_inst;
  assign b2.ex_br_taken = bus.ex_br_taken;
  assign b2.mem_req     = bus.mem_req;
  assign b2.mem_ack     = bus.mem_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en, ifid_en, ifid_clr, idex_en, idex_clr}
  wire [4:0] ctl = {bus.pc_en, bus.ifid_en, bus.ifid_clr, bus.idex_en, bus.idex_clr};

  localparam logic [4:0] C_DEF = 5'b11010;
  localparam logic [4:0] C_FRZ = 5'b00000;
  localparam logic [4:0] C_BR  = 5'b11111;
  localparam logic [4:0] C_LU  = 5'b00011;
  localparam logic [4:0] C_FL  = 5'b11110;

  localparam logic [31:0] LW_X5   = 32'h0000_2283;
  localparam logic [31:0] LW_X0   = 32'h0000_2003;
  localparam logic [31:0] ADD_X5  = 32'h0012_8333; // add x6,x5,x1
  localparam logic [31:0] ADD_X0  = 32'h0010_0333; // add x6,x0,x1
  localparam logic [31:0] LUI_R5  = 32'h0002_8337; // lui x6, rs1 field=5
  localparam logic [31:0] ADDI_R5 = 32'h0051_0093; // addi x1,x2,5 (rs2 field=5)
  localparam logic [31:0] SW_X5   = 32'h0051_0023; // sw x5,0(x2)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic cyc(input logic rst, input logic [31:0] id, input logic [31:0] ex,
                     input logic br, input logic req, input logic ack);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.id_inst     = id;
    bus.ex_inst     = ex;
    bus.ex_br_taken = br;
    bus.mem_req     = req;
    bus.mem_ack     = ack;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    cyc(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk({tag, " rst ctl"}, 64'(ctl), 64'(C_DEF));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk({tag, " post state"}, 64'(bus.state), 64'd0);
    chk({tag, " post stall"}, 64'(bus.stall_cnt), 64'd0);
    chk({tag, " post flush"}, 64'(bus.flush_cnt), 64'd0);
    chk({tag, " post tmo"}, 64'(bus.mem_timeout), 64'd0);
  endtask

  initial begin
    checks = 0;
    errs   = 0;
    // Reset with hostile inputs: outputs must still be the defaults.
    reset           = 1'b1;
    bus.id_inst     = ADD_X5;
    bus.ex_inst     = LW_X5;
    bus.ex_br_taken = 1'b1;
    bus.mem_req     = 1'b1;
    bus.mem_ack     = 1'b0;
    @(negedge clk);
    chk("init ctl", 64'(ctl), 64'(C_DEF));
    chk("init state", 64'(bus.state), 64'd0);
    chk("init stall", 64'(bus.stall_cnt), 64'd0);
    chk("init flush", 64'(bus.flush_cnt), 64'd0);
    chk("init tmo", 64'(bus.mem_timeout), 64'd0);

    // Load-use on rs1
    cyc(1'b0, ADD_X5, LW_X5, 1'b0, 1'b0, 1'b0);
    chk("lu ctl", 64'(ctl), 64'(C_LU));
    chk("lu state", 64'(bus.state), 64'd0);
    cyc(1'b0, ADD_X5, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("lu after ctl", 64'(ctl), 64'(C_DEF));
    chk("lu stall", 64'(bus.stall_cnt), 64'd1);

    // Non-hazards
    cyc(1'b0, ADD_X0, LW_X0, 1'b0, 1'b0, 1'b0);
    chk("lw x0 ctl", 64'(ctl), 64'(C_DEF));
    cyc(1'b0, ADD_X0, LW_X5, 1'b0, 1'b0, 1'b0);
    chk("id x0 ctl", 64'(ctl), 64'(C_DEF));
    cyc(1'b0, LUI_R5, LW_X5, 1'b0, 1'b0, 1'b0);
    chk("lui ctl", 64'(ctl), 64'(C_DEF));
    cyc(1'b0, ADDI_R5, LW_X5, 1'b0, 1'b0, 1'b0);
    chk("addi rs2 ctl", 64'(ctl), 64'(C_DEF));
    // Load-use on rs2
    cyc(1'b0, SW_X5, LW_X5, 1'b0, 1'b0, 1'b0);
    chk("sw rs2 ctl", 64'(ctl), 64'(C_LU));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("sw stall", 64'(bus.stall_cnt), 64'd2);

    // Taken branch
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("br ctl", 64'(ctl), 64'(C_BR));
    chk("br state", 64'(bus.state), 64'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("flush state", 64'(bus.state), 64'd1);
    chk("flush ctl", 64'(ctl), 64'(C_FL));
    chk("flush cnt", 64'(bus.flush_cnt), 64'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("flush exit state", 64'(bus.state), 64'd0);
    chk("flush exit ctl", 64'(ctl), 64'(C_DEF));

    // Branch wins over load-use
    cyc(1'b0, ADD_X5, LW_X5, 1'b1, 1'b0, 1'b0);
    chk("br+lu ctl", 64'(ctl), 64'(C_BR));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("br+lu state", 64'(bus.state), 64'd1);
    chk("br+lu stall", 64'(bus.stall_cnt), 64'd2);
    chk("br+lu flush", 64'(bus.flush_cnt), 64'd2);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("br+lu exit", 64'(bus.state), 64'd0);

    // Memstall during FLUSH: the pending IF/ID clear lands on ack
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pf br ctl", 64'(ctl), 64'(C_BR));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("pf fl state", 64'(bus.state), 64'd1);
    chk("pf fl ctl", 64'(ctl), 64'(C_FRZ));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("pf mw state", 64'(bus.state), 64'd2);
    chk("pf mw ctl", 64'(ctl), 64'(C_FRZ));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("pf ack state", 64'(bus.state), 64'd2);
    chk("pf ack ctl", 64'(ctl), 64'(C_FL));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("pf run state", 64'(bus.state), 64'd0);
    chk("pf run ctl", 64'(ctl), 64'(C_DEF));
    chk("pf stall", 64'(bus.stall_cnt), 64'd4);
    chk("pf flush", 64'(bus.flush_cnt), 64'd3);

    // Fourth branch: narrow flush counter saturates at 3
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("br4 flush", 64'(bus.flush_cnt), 64'd4);
    chk("sat flush", 64'(b2.flush_cnt), 64'd3);
    chk("sat stall", 64'(b2.stall_cnt), 64'd3);

    // Reset in the middle of MEM_WAIT
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("mw pre-rst state", 64'(bus.state), 64'd2);
    do_reset("mw");

    // Ack on the third MEM_WAIT cycle together with a taken branch
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("a3 c0 ctl", 64'(ctl), 64'(C_FRZ));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("a3 c1 state", 64'(bus.state), 64'd2);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("a3 c2 state", 64'(bus.state), 64'd2);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
    chk("a3 c3 state", 64'(bus.state), 64'd2);
    chk("a3 c3 ctl", 64'(ctl), 64'(C_BR));
    chk("a3 c3 stall", 64'(bus.stall_cnt), 64'd3);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("a3 c4 state", 64'(bus.state), 64'd1);
    chk("a3 c4 flush", 64'(bus.flush_cnt), 64'd1);
    chk("a3 c4 stall", 64'(bus.stall_cnt), 64'd3);

    // Timeout: MEM_WAIT cycles 1..255, ERR from cycle 256
    do_reset("tmo");
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("tmo c0 state", 64'(bus.state), 64'd0);
    for (int i = 1; i <= 255; i++) begin
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("tmo wait state", 64'(bus.state), 64'd2);
      chk("tmo wait flag", 64'(bus.mem_timeout), 64'd0);
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("tmo err state", 64'(bus.state), 64'd3);
    chk("tmo err flag", 64'(bus.mem_timeout), 64'd1);
    chk("tmo err stall", 64'(bus.stall_cnt), 64'd256);
    chk("tmo err ctl", 64'(ctl), 64'(C_FRZ));
    chk("tmo sat stall", 64'(b2.stall_cnt), 64'd3);
    cyc(1'b0, ADD_X5, LW_X5, 1'b1, 1'b1, 1'b1);
    chk("err sticky state", 64'(bus.state), 64'd3);
    chk("err sticky ctl", 64'(ctl), 64'(C_FRZ));
    chk("err stall", 64'(bus.stall_cnt), 64'd257);

    // Reset out of ERR with hostile inputs
    cyc(1'b1, ADD_X5, LW_X5, 1'b1, 1'b1, 1'b0);
    chk("err rst ctl", 64'(ctl), 64'(C_DEF));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("err rst state", 64'(bus.state), 64'd0);
    chk("err rst flag", 64'(bus.mem_timeout), 64'd0);
    chk("err rst stall", 64'(bus.stall_cnt), 64'd0);
    chk("err rst flush", 64'(bus.flush_cnt), 64'd0);
    chk("err rst ctl2", 64'(ctl), 64'(C_DEF));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum MEM_WAIT cycles before a memory timeout is declared; range 1..255.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 id_inst  in  32  instruction held in the IF/ID register; 0 denotes a bubble.
REQ-006 ex_inst  in  32  instruction in the EX stage.
REQ-007 ex_br_taken  in  1  branch or jump in EX resolved taken this cycle.
REQ-008 mem_req  in  1  data memory access outstanding in MEM stage.
REQ-009 mem_ack  in  1  data memory completes the access this cycle.
REQ-010 pc_en  out  1  PC update enable.
REQ-011 ifid_en  out  1  IF/ID register load enable.
REQ-012 ifid_clr  out  1  IF/ID register clear (insert bubble); overrides ifid_en.
REQ-013 idex_en  out  1  ID/EX register load enable.
REQ-014 idex_clr  out  1  ID/EX register clear (insert bubble); overrides idex_en.
REQ-015 state  out  2  FSM state: RUN=0, FLUSH=1, MEM_WAIT=2, ERR=3.
REQ-016 mem_timeout  out  1  high exactly when state==ERR.
REQ-017 stall_cnt  out  CNT_W  count of cycles with pc_en==0.
REQ-018 flush_cnt  out  CNT_W  count of taken branches accepted.

Function
REQ-019 State, wait_cnt (8 bit) and counters SHALL be registers; pc_en, ifid_en, ifid_clr, idex_en, idex_clr SHALL be combinational from current state and inputs.
REQ-020 memstall = mem_req & ~mem_ack.
REQ-021 Load-use hazard lu = ex opcode 7'b0000011 & ex rd (ex_inst[11:7]) != 0 & ((id uses rs1 & id_inst[19:15]==ex rd) | (id uses rs2 & id_inst[24:20]==ex rd)).
REQ-022 id uses rs1: id opcode in {0010011, 0000011, 1100111, 0110011, 0100011, 1100011}; id uses rs2: opcode in {0110011, 0100011, 1100011}; id_inst==0 never hazards.
REQ-023 Default outputs (no condition): pc_en=ifid_en=idex_en=1, clears 0.
REQ-024 RUN priority memstall > ex_br_taken > lu.
REQ-025 RUN & memstall: all enables 0, clears 0; wait_cnt<=1; next MEM_WAIT.
REQ-026 RUN & ex_br_taken: pc_en=1, ifid_clr=1, idex_clr=1; flush_cnt++; next FLUSH.
REQ-027 RUN & lu: pc_en=0, ifid_en=0, idex_clr=1; stay RUN (one-cycle bubble; rechecked next cycle).
REQ-028 FLUSH (second wrong-path fetch from synchronous IMEM): ifid_clr=1, pc_en=1, idex_en=1; next RUN; if memstall this cycle, RUN memstall rules apply instead, and the pending ifid clear SHALL still be applied on exit from MEM_WAIT.
REQ-029 MEM_WAIT & ~mem_ack: all enables 0; if wait_cnt==TIMEOUT_CYC next ERR, else wait_cnt++.
REQ-030 MEM_WAIT & mem_ack: outputs and next state evaluated with RUN rules for ex_br_taken and lu (memstall treated as 0).
REQ-031 ERR: all enables 0, clears 0; stays in ERR until reset.
REQ-032 stall_cnt, flush_cnt saturate at all-ones; no wrap.

Reset
REQ-033 reset high at posedge: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0, pending flush cleared; applies from any state, including mid-MEM_WAIT and ERR.
REQ-034 While reset is high, outputs SHALL be the RUN defaults (enables 1, clears 0) regardless of inputs.

Verification
REQ-035 ex_inst=lw x5 (opcode 0000011, rd=5), id_inst=add x6,x5,x1 -> one cycle pc_en=0, ifid_en=0, idex_clr=1; stall_cnt=1; next cycle (ex_inst=0) defaults.
REQ-036 ex_inst=lw x0, id uses x0, or id_inst=lui x6 with rs1 field=5 -> no stall.
REQ-037 ex_br_taken=1 in RUN -> ifid_clr=idex_clr=1 that cycle, state=FLUSH next with ifid_clr=1, then RUN; flush_cnt=1.
REQ-038 ex_br_taken=1 and lu together -> flush only; stall_cnt unchanged.
REQ-039 mem_req=1, mem_ack=0 from cycle 0 with TIMEOUT_CYC=255 -> MEM_WAIT cycles 1..255, state=ERR and mem_timeout=1 from cycle 256; stall_cnt=256 at cycle 256; reset -> RUN, counters 0.
REQ-040 mem_ack on third MEM_WAIT cycle with ex_br_taken=1 -> that cycle ifid_clr=idex_clr=1, next FLUSH; stall_cnt=3.
